mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  MEM stage of the 32-bit pipeline, directly downstream of the EX/MEM register and upstream of MEM/WB.
//  - Executes the load or store held in the EX/MEM register over a req/ack data bus.
//  - Aligns and extends load data, and forwards the write-back data and register controls.
//  - Holds the pipeline through stall_req_o until the bus access completes.
// PARAMETERS
//  TIMEOUT_CYCLES  64  bus wait limit before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk              in   1   clock
//  rst              in   1   reset, synchronous, active-low
//  result_i         in   32  ALU result; effective address for memory ops
//  MemData_i        in   32  store data
//  MemOp_i          in   3   memory op code (MEMOP_*)
//  WriteRegDst_i    in   5   destination register
//  RegWirte_i       in   1   register write enable
//  bus_req_o        out  1   bus request
//  bus_we_o         out  1   1 = write
//  bus_addr_o       out  32  word address {addr[31:2],2'b00}
//  bus_be_o         out  4   byte enables, bit i = byte lane i (little-endian)
//  bus_wdata_o      out  32  write data, lane-replicated
//  bus_rdata_i      in   32  read data, valid with ack
//  bus_ack_i        in   1   access complete, 1-cycle pulse
//  wb_data_o        out  32  data to MEM/WB
//  WriteRegDst_o    out  5   passed to MEM/WB
//  RegWirte_o       out  1   passed to MEM/WB; forced to 0 on error
//  stall_req_o      out  1   1 = hold PC/IF/ID/ID-EX/EX-MEM, bubble MEM/WB
//  mem_err_o        out  1   1-cycle pulse on misaligned access or timeout
// BEHAVIOUR
//  - MemOp: 0 NONE, 1 LW, 2 LB, 3 LBU, 4 LH, 5 LHU, 6 SW, 7 SB. SH is not supported.
//  - NONE: combinational pass-through in the same cycle.
//    - wb_data_o = result_i; stall_req_o = 0; bus_req_o = 0.
//  - FSM states: IDLE, WAIT, DONE.
//  - IDLE, memory op, aligned:
//    - bus_req_o = 1 and stall_req_o = 1, driven combinationally.
//    - A same-cycle ack goes to DONE; otherwise go to WAIT.
//  - WAIT: bus_req_o = 1 and stall_req_o = 1. On ack, capture the aligned data into hold_q and go to DONE.
//    - Address, data and be stay stable because the EX/MEM register is stalled.
//  - DONE: bus_req_o = 0, stall_req_o = 0, wb_data_o = hold_q, then unconditionally go to IDLE.
//    - The pipeline advances at the end of this cycle.
//  - Latency: ack in cycle k of the request (k >= 1), then DONE in cycle k+1.
//    - A memory op occupies at least 2 cycles.
//  - Store data/enables:
//    - SW: be = 4'b1111.
//    - SB: be = 1 << addr[1:0], wdata = {4{MemData_i[7:0]}}.
//    - Stores set wb_data_o = result_i; RegWirte_i passes unchanged.
//  - Load extraction by lane:
//    - LB/LBU: byte at lane addr[1:0], sign- or zero-extended to 32 bits.
//    - LH/LHU: half at lane addr[1], sign- or zero-extended.
//    - LW: whole word.
//    - Loads drive be = 4'b1111.
//  - Misaligned access (LW/SW with addr[1:0] != 0, LH/LHU with addr[0] != 0):
//    - No bus request is issued; stall_req_o = 0; RegWirte_o = 0.
//    - mem_err_o pulses 1 in the same cycle; the FSM stays in IDLE.
//  - bus_ack_i seen in IDLE or DONE is ignored.
//  - Reset values (rst = 0 at a clk edge):
//    - state = IDLE, hold_q = 0, timeout counter = 0.
//    - All bus outputs 0; stall_req_o = 0; mem_err_o = 0.
//    - WriteRegDst_o = 0, RegWirte_o = 0, wb_data_o = 0.
//  - Reset in WAIT drops bus_req_o in the cycle after the edge. A late ack is ignored.
// CONFIGURATION
//  - MEM_TIMEOUT_EN defined:
//    - A counter in WAIT counts cycles without ack.
//    - When it reaches TIMEOUT_CYCLES, go to DONE with hold_q = 0, RegWirte_o = 0 and a mem_err_o pulse.
//    - The counter clears in IDLE.
//  - MEM_TIMEOUT_EN undefined: no counter; WAIT lasts until ack (may hang).
// STRUCTURE
//  - Shared defines header: MEMOP_* codes, the 3-state FSM encoding, ZeroWord.
//  - One sub-module, mem_load_align: a combinational lane-select and sign/zero-extend unit.
//    - Inputs: rdata, addr[1:0], MemOp. Output: 32-bit data.
//    - It is also reused for the store lane/be generation table.
// TESTING
//  - ADD result 0x1234, MemOp NONE -> same cycle: wb_data 0x1234, stall 0, bus_req 0.
//  - LB addr 0x1003, ack after 3 cycles with rdata 0x80FF_FFFF:
//    -> stall high 3 cycles, then DONE with wb_data 0xFFFF_FF80 and stall 0.
//  - SB addr 0x2001, data 0xAB, immediate ack:
//    -> bus_be 4'b0010, wdata 0xABAB_ABAB, we 1, 2-cycle op.
//  - LW addr 0x0006 -> no bus_req, mem_err pulse, RegWirte_o 0, stall 0.
//  - Reset asserted in WAIT, ack on the following cycle:
//    -> state IDLE, bus_req 0 after the edge, ack ignored, all outputs 0.
//  - MEM_TIMEOUT_EN, TIMEOUT_CYCLES 4, no ack -> after 4 WAIT cycles: mem_err pulse, RegWirte_o 0, stall released.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: memory op codes, FSM encoding,
// ZeroWord and small op-classification helpers.
package mem_access_pkg;

  localparam logic [2:0] MEMOP_NONE = 3'd0;
  localparam logic [2:0] MEMOP_LW   = 3'd1;
  localparam logic [2:0] MEMOP_LB   = 3'd2;
  localparam logic [2:0] MEMOP_LBU  = 3'd3;
  localparam logic [2:0] MEMOP_LH   = 3'd4;
  localparam logic [2:0] MEMOP_LHU  = 3'd5;
  localparam logic [2:0] MEMOP_SW   = 3'd6;
  localparam logic [2:0] MEMOP_SB   = 3'd7;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // One-hot-free lane table: byte i of this word is (1 << i).
  // Selecting a byte lane from it yields the SB byte enable.
  localparam logic [31:0] BE_LANE_TBL = 32'h0804_0201;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  function automatic logic op_is_load(
    input logic [2:0] op
  );
    return (op == MEMOP_LW)  || (op == MEMOP_LB) ||
           (op == MEMOP_LBU) || (op == MEMOP_LH) ||
           (op == MEMOP_LHU);
  endfunction

  function automatic logic op_is_store(
    input logic [2:0] op
  );
    return (op == MEMOP_SW) || (op == MEMOP_SB);
  endfunction

  function automatic logic op_misaligned(
    input logic [2:0] op,
    input logic [1:0] lo
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (op == MEMOP_LW),
      (op == MEMOP_SW):  r = (lo != 2'b00);
      (op == MEMOP_LH),
      (op == MEMOP_LHU): r = lo[0];
      default:           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Lane select plus sign/zero extend for loads; also used as a
// byte-lane lookup for store byte enables.
// Ports: i_rdata word in, i_addr byte offset, i_memop op, o_data result.
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_memop,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    unique case (i_addr)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_half = 16'h0000;
    w_half = i_addr[1] ? i_rdata[31:16]
                       : i_rdata[15:0];
  end

  always_comb begin
    o_data = i_rdata;
    unique case (1'b1)
      (i_memop == MEMOP_LB):
        o_data = {{24{w_byte[7]}}, w_byte};
      (i_memop == MEMOP_LBU):
        o_data = {24'h000000, w_byte};
      (i_memop == MEMOP_LH):
        o_data = {{16{w_half[15]}}, w_half};
      (i_memop == MEMOP_LHU):
        o_data = {16'h0000, w_half};
      default:
        o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: runs the EX/MEM load/store over a req/ack bus, aligns
// load data and stalls the pipe until the access completes.
// Ports: clk/rst (sync, active-low); result_i, MemData_i, MemOp_i,
//   WriteRegDst_i, RegWirte_i from EX/MEM; bus_* req/ack data bus;
//   wb_data_o, WriteRegDst_o, RegWirte_o to MEM/WB; stall_req_o,
//   mem_err_o status.
// Build option: define MEM_TIMEOUT_EN to abort WAIT after
//   TIMEOUT_CYCLES cycles without ack.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result_i,
  input  logic [31:0] MemData_i,
  input  logic [2:0]  MemOp_i,
  input  logic [4:0]  WriteRegDst_i,
  input  logic        RegWirte_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic [31:0] wb_data_o,
  output logic [4:0]  WriteRegDst_o,
  output logic        RegWirte_o,
  output logic        stall_req_o,
  output logic        mem_err_o
);

  mem_state_e r_state;
  mem_state_e w_next;

  logic [31:0] r_hold;
  logic        r_in_rst;
  logic        r_tmo_err;

  logic        w_mem;
  logic        w_load;
  logic        w_store;
  logic        w_misal;
  logic        w_issue;
  logic        w_req;
  logic        w_tmo_hit;
  logic [31:0] w_ld_data;
  logic [31:0] w_be_tbl;
  logic [3:0]  w_sb_be;
  logic [27:0] w_unused_be;

  assign w_mem   = (MemOp_i != MEMOP_NONE);
  assign w_load  = op_is_load(MemOp_i);
  assign w_store = op_is_store(MemOp_i);
  assign w_misal = op_misaligned(MemOp_i, result_i[1:0]);

  // r_in_rst remembers that rst was sampled low, so outputs read
  // as zero from the edge after reset until the edge after release.
  assign w_issue = !r_in_rst && (r_state == ST_IDLE) &&
                   w_mem && !w_misal;
  assign w_req   = w_issue || (r_state == ST_WAIT);

  mem_load_align u_ld_align (
    .i_rdata (bus_rdata_i),
    .i_addr  (result_i[1:0]),
    .i_memop (MemOp_i),
    .o_data  (w_ld_data)
  );

  // Byte-lane pick from the lane table gives 1 << addr[1:0].
  mem_load_align u_be_align (
    .i_rdata (BE_LANE_TBL),
    .i_addr  (result_i[1:0]),
    .i_memop (MEMOP_LBU),
    .o_data  (w_be_tbl)
  );

  assign {w_unused_be, w_sb_be} = w_be_tbl;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_WAIT && !bus_ack_i) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_tmo_hit = (r_state == ST_WAIT) && !bus_ack_i &&
                     (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;

  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    r_in_rst <= !rst;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold    <= ZeroWord;
      r_tmo_err <= 1'b0;
    end else begin
      r_tmo_err <= w_tmo_hit;
      if (w_req && bus_ack_i) begin
        r_hold <= w_ld_data;
      end else if (w_tmo_hit) begin
        r_hold <= ZeroWord;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_next = bus_ack_i ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus_ack_i || w_tmo_hit) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_req_o     = 1'b0;
    bus_we_o      = 1'b0;
    bus_addr_o    = ZeroWord;
    bus_be_o      = 4'b0000;
    bus_wdata_o   = ZeroWord;
    wb_data_o     = ZeroWord;
    WriteRegDst_o = 5'd0;
    RegWirte_o    = 1'b0;
    stall_req_o   = 1'b0;
    mem_err_o     = 1'b0;
    if (!r_in_rst) begin
      WriteRegDst_o = WriteRegDst_i;
      RegWirte_o    = RegWirte_i;
      wb_data_o     = w_load ? r_hold : result_i;
      unique case (r_state)
        ST_IDLE: begin
          if (w_mem && w_misal) begin
            mem_err_o  = 1'b1;
            RegWirte_o = 1'b0;
          end else if (w_mem) begin
            bus_req_o   = 1'b1;
            stall_req_o = 1'b1;
          end
        end
        ST_WAIT: begin
          bus_req_o   = 1'b1;
          stall_req_o = 1'b1;
        end
        ST_DONE: begin
          if (r_tmo_err) begin
            mem_err_o  = 1'b1;
            RegWirte_o = 1'b0;
          end
        end
        default: begin
          bus_req_o = 1'b0;
        end
      endcase
      if (w_req) begin
        bus_we_o   = w_store;
        bus_addr_o = {result_i[31:2], 2'b00};
        bus_be_o   = (MemOp_i == MEMOP_SB) ? w_sb_be
                                           : 4'b1111;
        if (MemOp_i == MEMOP_SB) begin
          bus_wdata_o = {4{MemData_i[7:0]}};
        end else if (MemOp_i == MEMOP_SW) begin
          bus_wdata_o = MemData_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus random
// loads/stores against an arithmetic reference model.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] result_i = '0;
  logic [31:0] MemData_i = '0;
  logic [2:0]  MemOp_i = '0;
  logic [4:0]  WriteRegDst_i = '0;
  logic        RegWirte_i = 1'b0;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_ack_i = 1'b0;
  logic [31:0] wb_data_o;
  logic [4:0]  WriteRegDst_o;
  logic        RegWirte_o;
  logic        stall_req_o;
  logic        mem_err_o;

  int checks = 0;
  int errors = 0;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .result_i      (result_i),
    .MemData_i     (MemData_i),
    .MemOp_i       (MemOp_i),
    .WriteRegDst_i (WriteRegDst_i),
    .RegWirte_i    (RegWirte_i),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_be_o      (bus_be_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_rdata_i   (bus_rdata_i),
    .bus_ack_i     (bus_ack_i),
    .wb_data_o     (wb_data_o),
    .WriteRegDst_o (WriteRegDst_o),
    .RegWirte_o    (RegWirte_o),
    .stall_req_o   (stall_req_o),
    .mem_err_o     (mem_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] op,
      input logic [31:0] a, input logic [31:0] rd);
    int lane;
    logic [31:0] v;
    lane = int'(a % 4);
    v = rd;
    if (op == MEMOP_LB || op == MEMOP_LBU) begin
      v = (rd >> (8 * lane)) & 32'hFF;
      if (op == MEMOP_LB && v >= 32'h80) v = v - 32'h100;
    end else if (op == MEMOP_LH || op == MEMOP_LHU) begin
      v = (rd >> (16 * (lane / 2))) & 32'hFFFF;
      if (op == MEMOP_LH && v >= 32'h8000) v = v - 32'h10000;
    end
    return v;
  endfunction

  function automatic bit ref_misal(input logic [2:0] op,
                                   input logic [31:0] a);
    if (op == MEMOP_LW || op == MEMOP_SW) return (a % 4) != 0;
    if (op == MEMOP_LH || op == MEMOP_LHU) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic bit ref_load_op(input logic [2:0] op);
    return op >= 3'd1 && op <= 3'd5;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] a,
      input logic [31:0] d, input logic rw, input logic [4:0] dst);
    MemOp_i = op;
    result_i = a;
    MemData_i = d;
    RegWirte_i = rw;
    WriteRegDst_i = dst;
  endtask

  // Inputs already driven at a negedge with FSM idle; ack in cycle k.
  task automatic do_mem(input int k, input logic [31:0] rd);
    logic [3:0]  be_exp;
    logic [31:0] wd_exp;
    logic [31:0] wb_exp;
    be_exp = 4'hF;
    wd_exp = MemData_i;
    if (MemOp_i == MEMOP_SB) begin
      be_exp = 4'(1 << (result_i % 4));
      wd_exp = MemData_i[7:0] * 32'h0101_0101;
    end
    wb_exp = ref_load_op(MemOp_i) ? ref_load(MemOp_i, result_i, rd)
                                  : result_i;
    for (int c = 1; c <= k; c++) begin
      if (c > 1) @(negedge clk);
      bus_ack_i = (c == k);
      bus_rdata_i = (c == k) ? rd : $urandom;
      #1;
      chk("req", 32'(bus_req_o), 1);
      chk("stall", 32'(stall_req_o), 1);
      if (c == 1) begin
        chk("addr", bus_addr_o, result_i & 32'hFFFF_FFFC);
        chk("be", 32'(bus_be_o), 32'(be_exp));
        chk("we", 32'(bus_we_o), 32'(MemOp_i >= 3'd6));
        if (MemOp_i >= 3'd6) chk("wdata", bus_wdata_o, wd_exp);
      end
    end
    @(negedge clk);
    bus_ack_i = 1'b0;
    bus_rdata_i = $urandom;
    #1;
    chk("done_stall", 32'(stall_req_o), 0);
    chk("done_req", 32'(bus_req_o), 0);
    chk("done_err", 32'(mem_err_o), 0);
    chk("done_wb", wb_data_o, wb_exp);
    chk("done_rw", 32'(RegWirte_o), 32'(RegWirte_i));
    chk("done_dst", 32'(WriteRegDst_o), 32'(WriteRegDst_i));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, 32'(bus_req_o), 0);
    chk({tag, "_we"}, 32'(bus_we_o), 0);
    chk({tag, "_addr"}, bus_addr_o, 0);
    chk({tag, "_be"}, 32'(bus_be_o), 0);
    chk({tag, "_wdata"}, bus_wdata_o, 0);
    chk({tag, "_wb"}, wb_data_o, 0);
    chk({tag, "_dst"}, 32'(WriteRegDst_o), 0);
    chk({tag, "_rw"}, 32'(RegWirte_o), 0);
    chk({tag, "_stall"}, 32'(stall_req_o), 0);
    chk({tag, "_err"}, 32'(mem_err_o), 0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    // reset with a live load presented: outputs must be quiet
    drive(MEMOP_LW, 32'h100, 32'h0, 1'b1, 5'd5);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_all_zero("rst");
    drive(MEMOP_NONE, 32'h0, 32'h0, 1'b0, 5'd0);
    rst = 1'b1;
    @(negedge clk);

    // NONE pass-through, stray ack ignored
    @(negedge clk);
    drive(MEMOP_NONE, 32'h1234, 32'h0, 1'b1, 5'd3);
    bus_ack_i = 1'b1;
    #1;
    chk("none_wb", wb_data_o, 32'h1234);
    chk("none_stall", 32'(stall_req_o), 0);
    chk("none_req", 32'(bus_req_o), 0);
    chk("none_rw", 32'(RegWirte_o), 1);
    chk("none_dst", 32'(WriteRegDst_o), 3);

    // LB 0x1003, ack in 3rd cycle
    @(negedge clk);
    bus_ack_i = 1'b0;
    drive(MEMOP_LB, 32'h1003, 32'h0, 1'b1, 5'd7);
    do_mem(3, 32'h80FF_FFFF);
    chk("lb_wb_lit", wb_data_o, 32'hFFFF_FF80);

    // SB 0x2001 immediate ack
    @(negedge clk);
    drive(MEMOP_SB, 32'h2001, 32'h0000_00AB, 1'b0, 5'd0);
    do_mem(1, 32'h0);

    // misaligned LW
    @(negedge clk);
    drive(MEMOP_LW, 32'h0006, 32'h0, 1'b1, 5'd9);
    #1;
    chk("mis_req", 32'(bus_req_o), 0);
    chk("mis_stall", 32'(stall_req_o), 0);
    chk("mis_err", 32'(mem_err_o), 1);
    chk("mis_rw", 32'(RegWirte_o), 0);
    @(negedge clk);
    drive(MEMOP_NONE, 32'h77, 32'h0, 1'b1, 5'd1);
    #1;
    chk("mis_after_err", 32'(mem_err_o), 0);

    // reset while in WAIT, ack on the following cycle
    @(negedge clk);
    drive(MEMOP_LW, 32'h40, 32'h0, 1'b1, 5'd4);
    #1;
    chk("rw_req1", 32'(bus_req_o), 1);
    @(negedge clk); #1;
    chk("rw_wait_req", 32'(bus_req_o), 1);
    rst = 1'b0;
    @(negedge clk);
    bus_ack_i = 1'b1;
    bus_rdata_i = 32'hDEAD_BEEF;
    #1;
    check_all_zero("rwait");
    @(negedge clk);
    bus_ack_i = 1'b0;
    drive(MEMOP_NONE, 32'h55, 32'h0, 1'b1, 5'd2);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rel_wb", wb_data_o, 32'h55);
    chk("rel_stall", 32'(stall_req_o), 0);
    @(negedge clk);
    drive(MEMOP_LW, 32'h40, 32'h0, 1'b1, 5'd4);
    do_mem(2, 32'h1357_9BDF);

`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    drive(MEMOP_LW, 32'h80, 32'h0, 1'b1, 5'd6);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      chk("tmo_stall", 32'(stall_req_o), 1);
    end
    @(negedge clk); #1;
    chk("tmo_err", 32'(mem_err_o), 1);
    chk("tmo_rw", 32'(RegWirte_o), 0);
    chk("tmo_stall_rel", 32'(stall_req_o), 0);
    chk("tmo_wb", wb_data_o, 32'h0);
    @(negedge clk);
    drive(MEMOP_NONE, 32'h9, 32'h0, 1'b1, 5'd6);
    #1;
    chk("tmo_after_err", 32'(mem_err_o), 0);
`endif

    // random ops against the reference model
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      drive(op, a, $urandom, 1'($urandom), 5'($urandom));
      if (op == MEMOP_NONE) begin
        #1;
        chk("r_none_wb", wb_data_o, a);
        chk("r_none_stall", 32'(stall_req_o), 0);
      end else if (ref_misal(op, a)) begin
        #1;
        chk("r_mis_err", 32'(mem_err_o), 1);
        chk("r_mis_req", 32'(bus_req_o), 0);
        chk("r_mis_rw", 32'(RegWirte_o), 0);
      end else begin
        do_mem($urandom_range(1, 4), $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
